// File: rtl/rr_arb16.sv
// Round-robin arbiter for a shared 16:1 select path: one owner at a time,
// bursts bounded by MAX_HOLD under contention, all outputs registered.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner, gnt=0, sel keeps its last value
// OWN   | owner holds the path, cnt counts cycles of this ownership
module rr_arb16 #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic [3:0]  sel,
   output logic        busy,
   output logic [7:0]  hold_cnt
);

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   state_t      state, state_n;
   logic [3:0]  owner, owner_n;
   logic [3:0]  ptr, ptr_n;
   logic [7:0]  cnt, cnt_n;
   logic [15:0] gnt_n;
   logic [3:0]  sel_n;
   logic [15:0] others;
   logic        release_own;

   // First set bit of r at or after p, wrapping 15 -> 0.
   function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] p);
      logic [3:0] idx;
      logic       found;
      pick  = p;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         idx = p + 4'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   assign others      = req & ~(16'h0001 << owner);
   assign release_own = !req[owner] || ((cnt == MAX_HOLD_C) && (others != 16'h0000));

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (req != 16'h0000) begin
               owner_n = pick(req, ptr);
               state_n = OWN;
               cnt_n   = 8'd1;
            end
         end
         OWN: begin
            if (!release_own) begin
               // Saturation only happens when the owner is alone.
               if (cnt != MAX_HOLD_C)
                  cnt_n = cnt + 8'd1;
            end else begin
               ptr_n = owner + 4'd1;
               if (others != 16'h0000) begin
                  owner_n = pick(others, owner + 4'd1);
                  cnt_n   = 8'd1;
               end else begin
                  state_n = IDLE;
                  cnt_n   = 8'd0;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      gnt_n = 16'h0000;
      sel_n = sel;
      if (state_n == OWN) begin
         gnt_n = 16'h0001 << owner_n;
         sel_n = owner_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= 4'd0;
         ptr      <= 4'd0;
         cnt      <= 8'd0;
         gnt      <= 16'h0000;
         sel      <= 4'd0;
         busy     <= 1'b0;
         hold_cnt <= 8'd0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         ptr      <= ptr_n;
         cnt      <= cnt_n;
         gnt      <= gnt_n;
         sel      <= sel_n;
         busy     <= (state_n == OWN);
         hold_cnt <= (state_n == OWN) ? cnt_n : 8'd0;
      end
   end

endmodule
